spi_request_arbiter: RTL and testbench
======================================

// Module: spi_request_arbiter
// PURPOSE
//  Shares one spi_master_slave instance between NUM_REQ requesters (e.g. multiplier result path, UART command path).
//  Each requester asks for one 16-bit frame with its own mode (tx/rx) and SCLK rate.
//  A round-robin scheduler starts the SPI engine and waits for completion or timeout.
//  It returns the received word and enforces an idle gap so the engine is back in IDLE before the next start.
// PARAMETERS
//  NUM_REQ         2     number of requesters (2..4)
//  GAP_CYCLES      64    clk cycles in GAP after a frame; must exceed 5*10+2 (engine WAIT at slowest rate)
//  TIMEOUT_CYCLES  1024  max clk cycles in BUSY before abort
// PORTS
//  clk           in   1           system clock
//  reset         in   1           synchronous, active-high reset
//  req           in   NUM_REQ     request level per requester; hold until req_ack
//  req_mode      in   2*NUM_REQ   per requester [1]=rx, [0]=tx
//  req_data      in   16*NUM_REQ  per requester tx word
//  req_freq      in   2*NUM_REQ   per requester SCLK select (00=50M 01=25M 10=10M 11=5M)
//  req_ack       out  NUM_REQ     1-cycle pulse: request accepted, inputs latched
//  rsp_valid     out  NUM_REQ     1-cycle pulse to the granted requester: frame finished
//  rsp_data      out  16          received word, valid with rsp_valid
//  rsp_err       out  1           valid with rsp_valid: 1 = timeout or illegal mode
//  busy          out  1           high in any state except IDLE
//  spi_rx_start  out  1           to engine slave_rx_start
//  spi_tx_start  out  1           to engine slave_tx_start
//  spi_tx_data   out  16          to engine input_reg_data
//  spi_freq      out  2           to engine freq_control
//  spi_rx_valid  in   1           from engine rx_valid
//  spi_tx_done   in   1           from engine tx_done
//  spi_rx_data   in   16          from engine output_reg_data
// BEHAVIOUR
//  Reset: all outputs 0, spi_freq=2'b11, state IDLE, rr pointer=0, counters 0.
//  Engine shares the same reset.
//  FSM: IDLE -> START -> BUSY -> RESP -> GAP -> IDLE.
//  IDLE
//   - Arbitrate if any req is high. Winner = first asserted index at or after rr pointer, wrapping modulo NUM_REQ.
//   - Same edge: pulse req_ack[w]; latch mode/data/freq into spi_tx_data, spi_freq, internal mode reg.
//   - Set rr pointer = w+1 (wraps to 0). Go to START.
//   - Latched mode 00 (illegal): skip SPI and go straight to RESP with err=1, data=0.
//  START (1 cycle)
//   - spi_tx_start=mode[0], spi_rx_start=mode[1].
//   - Both low on every other cycle. Go to BUSY, clear timer.
//  BUSY
//   - Wait for spi_rx_valid | spi_tx_done. On that edge capture spi_rx_data (err=0) and go to RESP.
//   - Otherwise increment timer. At timer==TIMEOUT_CYCLES-1 go to RESP with err=1, data=0.
//   - Completion on the same cycle as expiry: completion wins, err=0.
//  RESP (1 cycle)
//   - rsp_valid[w]=1; rsp_data/rsp_err driven, held until next RESP.
//   - Go to GAP.
//  GAP
//   - Count GAP_CYCLES, then IDLE.
//   - Reqs are ignored; no ack is issued in GAP.
//  spi_freq and spi_tx_data stay stable from IDLE grant through end of GAP.
//  Latency: req high in IDLE -> ack same edge -> start next cycle.
//   - Min req-to-rsp = frame time + 3 cycles.
//   - Back-to-back grants are >= GAP_CYCLES+3 apart.
//  Requester dropping req before ack: request withdrawn, no side effects.
//  req still high after rsp_valid: new request, arbitrated normally after GAP.
//  reset mid-frame: next edge returns to reset values.
//   - No rsp_valid or ack for the aborted frame.
//   - rr pointer returns to 0.
// TESTING
//  1. Single req0, mode=01 (tx), data=16'hA5C3, freq=10 -> one ack0; spi_tx_start pulse 1 cycle later; MOSI=A5C3 MSB first; rsp_valid0 with err=0.
//  2. req0 and req1 high together, repeatedly -> grants alternate 0,1,0,1; gap between grants >= GAP_CYCLES+3.
//  3. req1, mode=10 (rx), slave returns 16'h1234 -> rsp_valid1, rsp_data=16'h1234; spi_tx_start never asserted.
//  4. Engine done tied low -> rsp_err=1, rsp_data=0 exactly TIMEOUT_CYCLES after BUSY entry; then GAP, then IDLE.
//  5. req with mode=00 -> ack, rsp_valid 2 cycles later with err=1; no spi start; arbiter then enters GAP.
//  6. reset asserted mid-BUSY -> next edge: busy=0, all outputs at reset values; post-reset req0 completes normally.

Source files
------------

// File: rtl/spi_request_arbiter.sv
// Round-robin arbiter that shares one SPI engine among NUM_REQ requesters.
// Each grant runs one 16-bit frame, returns the result, then holds an idle gap.
module spi_request_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int GAP_CYCLES     = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [2*NUM_REQ-1:0]  req_mode,
    input  logic [16*NUM_REQ-1:0] req_data,
    input  logic [2*NUM_REQ-1:0]  req_freq,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [15:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  spi_rx_start,
    output logic                  spi_tx_start,
    output logic [15:0]           spi_tx_data,
    output logic [1:0]            spi_freq,
    input  logic                  spi_rx_valid,
    input  logic                  spi_tx_done,
    input  logic [15:0]           spi_rx_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_RESP,
        S_GAP
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   rr_ptr, grant, win;
    logic               win_found;
    logic [1:0]         mode_q;
    logic [TMR_W-1:0]   timer;
    logic [GAP_W-1:0]   gap_cnt;
    logic [15:0]        res_data;
    logic               res_err;

    logic [NUM_REQ-1:0] ack_d, rsp_valid_d;
    logic               tx_start_d, rx_start_d;
    logic               grant_load, cap_ok, cap_err, rsp_load;
    logic               timer_clr, timer_inc, gap_clr, gap_inc;

    assign busy = (state != S_IDLE);

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win       = rr_ptr;
        win_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win       = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d     = state;
        ack_d       = '0;
        rsp_valid_d = '0;
        tx_start_d  = 1'b0;
        rx_start_d  = 1'b0;
        grant_load  = 1'b0;
        cap_ok      = 1'b0;
        cap_err     = 1'b0;
        rsp_load    = 1'b0;
        timer_clr   = 1'b0;
        timer_inc   = 1'b0;
        gap_clr     = 1'b0;
        gap_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|req) begin
                    grant_load = 1'b1;
                    ack_d[win] = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                tx_start_d = mode_q[0];
                rx_start_d = mode_q[1];
                timer_clr  = 1'b1;
                if (mode_q == 2'b00) begin
                    cap_err = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Completion is checked first so it beats a coincident timeout.
                if (spi_rx_valid || spi_tx_done) begin
                    cap_ok  = 1'b1;
                    state_d = S_RESP;
                end else if (timer == TMR_LAST) begin
                    cap_err = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            S_RESP: begin
                rsp_valid_d[grant] = 1'b1;
                rsp_load           = 1'b1;
                gap_clr            = 1'b1;
                state_d            = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_d = S_IDLE;
                else                     gap_inc = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            mode_q       <= 2'b00;
            timer        <= '0;
            gap_cnt      <= '0;
            res_data     <= '0;
            res_err      <= 1'b0;
            req_ack      <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            spi_rx_start <= 1'b0;
            spi_tx_start <= 1'b0;
            spi_tx_data  <= '0;
            spi_freq     <= 2'b11;
        end else begin
            state        <= state_d;
            req_ack      <= ack_d;
            rsp_valid    <= rsp_valid_d;
            spi_tx_start <= tx_start_d;
            spi_rx_start <= rx_start_d;
            if (grant_load) begin
                grant       <= win;
                rr_ptr      <= (win == IDX_LAST) ? '0 : win + 1'b1;
                mode_q      <= req_mode[int'(win)*2 +: 2];
                spi_tx_data <= req_data[int'(win)*16 +: 16];
                spi_freq    <= req_freq[int'(win)*2 +: 2];
            end
            if (cap_ok) begin
                res_data <= spi_rx_data;
                res_err  <= 1'b0;
            end else if (cap_err) begin
                res_data <= '0;
                res_err  <= 1'b1;
            end
            if (rsp_load) begin
                rsp_data <= res_data;
                rsp_err  <= res_err;
            end
            if (timer_clr)      timer <= '0;
            else if (timer_inc) timer <= timer + 1'b1;
            if (gap_clr)        gap_cnt <= '0;
            else if (gap_inc)   gap_cnt <= gap_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_request_arbiter.sv
// Self-checking bench for spi_request_arbiter: directed table, held-request
// alternation, mid-frame reset and randomized rounds against a request-level model.
module tb_spi_request_arbiter;

    localparam int N = 3;
    localparam int G = 64;
    localparam int T = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [2*N-1:0]    req_mode;
    logic [16*N-1:0]   req_data;
    logic [2*N-1:0]    req_freq;
    logic [N-1:0]      req_ack;
    logic [N-1:0]      rsp_valid;
    logic [15:0]       rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              spi_rx_start;
    logic              spi_tx_start;
    logic [15:0]       spi_tx_data;
    logic [1:0]        spi_freq;
    logic              spi_rx_valid;
    logic              spi_tx_done;
    logic [15:0]       spi_rx_data;

    spi_request_arbiter #(
        .NUM_REQ(N), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .reset(reset),
        .req(req), .req_mode(req_mode), .req_data(req_data), .req_freq(req_freq),
        .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .spi_rx_start(spi_rx_start), .spi_tx_start(spi_tx_start),
        .spi_tx_data(spi_tx_data), .spi_freq(spi_freq),
        .spi_rx_valid(spi_rx_valid), .spi_tx_done(spi_tx_done), .spi_rx_data(spi_rx_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int model_rr = 0;
    int grant_cyc = 0;

    logic [1:0]  md[N];
    logic [15:0] dt[N];
    logic [1:0]  fq[N];

    typedef struct {
        logic [N-1:0] mask;
        logic [1:0]   mode;
        logic [15:0]  data;
        logic [1:0]   freq;
        int           dly;
        bit           hang;
        logic [15:0]  rx;
        int           exp_w;
        logic [15:0]  exp_data;
        bit           exp_err;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_mode[2*i +: 2]  = md[i];
            req_data[16*i +: 16] = dt[i];
            req_freq[2*i +: 2]  = fq[i];
        end
    endtask

    // Round-robin rule: first asserted requester at or after the pointer, wrapping.
    function automatic int model_winner(input logic [N-1:0] m);
        for (int k = 0; k < N; k++)
            if (m[(model_rr + k) % N]) return (model_rr + k) % N;
        return -1;
    endfunction

    // Called at a negedge with the arbiter idle and requests already driven.
    // Plays the engine, checks ack, start pulse, response timing and the gap.
    task automatic serve(input int exp_w, input logic [15:0] exp_data, input bit exp_err,
                         input int dly, input bit hang, input logic [15:0] rx, input bit keep);
        int r, n, lat;
        bit got, bad, drive;
        logic [1:0] m;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (req_ack != '0) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL ack_timeout: no req_ack within 8 cycles, expected winner %0d", exp_w);
            return;
        end
        grant_cyc = cyc;
        check("ack_latency", 32'(lat), 32'd1);
        check("ack_onehot", 32'(req_ack), 32'(1 << exp_w));
        check("tx_data_latched", 32'(spi_tx_data), 32'(dt[exp_w]));
        check("freq_latched", 32'(spi_freq), 32'(fq[exp_w]));
        model_rr = (exp_w + 1) % N;
        m = md[exp_w];
        if (!keep) req[exp_w] = 1'b0;

        @(negedge clk);
        n = 1;
        check("start_bits", 32'({spi_rx_start, spi_tx_start}), 32'(m));
        drive = (m != 2'b00) && !hang;
        if (m == 2'b00) r = 2;
        else if (hang)  r = T + 2;
        else            r = dly + 3;
        bad = 1'b0;
        while (n < r) begin
            if (drive && n == dly + 1) begin
                spi_tx_done  = m[0];
                spi_rx_valid = m[1];
                spi_rx_data  = rx;
            end
            @(negedge clk);
            n++;
            if (n == dly + 2) begin
                spi_tx_done  = 1'b0;
                spi_rx_valid = 1'b0;
            end
            if (n < r && (rsp_valid != '0 || req_ack != '0 || spi_tx_start || spi_rx_start || !busy))
                bad = 1'b1;
        end
        spi_tx_done  = 1'b0;
        spi_rx_valid = 1'b0;
        check("no_early_rsp", 32'(bad), 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'(1 << exp_w));
        check("rsp_data", 32'(rsp_data), 32'(exp_data));
        check("rsp_err", 32'(rsp_err), 32'(exp_err));

        bad = 1'b0;
        repeat (G - 1) begin
            @(negedge clk);
            if (!busy || req_ack != '0 || rsp_valid != '0 || rsp_data !== exp_data ||
                rsp_err !== exp_err || spi_tx_data !== dt[exp_w] || spi_freq !== fq[exp_w])
                bad = 1'b1;
        end
        check("gap_quiet", 32'(bad), 32'd0);
        @(negedge clk);
        check("idle_after_gap", 32'({busy, req_ack != '0}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w, dly, prev;
        bit hang, err;
        logic [15:0] rx, exp_d;
        logic [N-1:0] mask;

        //          mask    mode   data      freq   dly hang rx        win data      err
        tbl[0] = '{3'b001, 2'b01, 16'hA5C3, 2'b10, 5,  0, 16'h00FF, 0, 16'h00FF, 0};
        tbl[1] = '{3'b010, 2'b10, 16'h0000, 2'b11, 3,  0, 16'h1234, 1, 16'h1234, 0};
        tbl[2] = '{3'b011, 2'b11, 16'h5A5A, 2'b00, 0,  0, 16'hBEEF, 0, 16'hBEEF, 0};
        tbl[3] = '{3'b111, 2'b11, 16'h0F0F, 2'b01, 7,  0, 16'hCAFE, 1, 16'hCAFE, 0};
        tbl[4] = '{3'b111, 2'b00, 16'h1111, 2'b10, 0,  0, 16'hFFFF, 2, 16'h0000, 1};
        tbl[5] = '{3'b110, 2'b01, 16'h2222, 2'b11, 0,  1, 16'hABCD, 1, 16'h0000, 1};
        tbl[6] = '{3'b101, 2'b10, 16'h3333, 2'b00, 2,  0, 16'h8001, 2, 16'h8001, 0};
        tbl[7] = '{3'b101, 2'b01, 16'h4444, 2'b01, 9,  0, 16'h7E7E, 0, 16'h7E7E, 0};

        reset = 1'b1;
        req = '0;
        spi_rx_valid = 1'b0;
        spi_tx_done = 1'b0;
        spi_rx_data = '0;
        for (int i = 0; i < N; i++) begin md[i] = 2'b00; dt[i] = '0; fq[i] = 2'b00; end
        pack();
        repeat (3) @(negedge clk);
        check("reset_flags", 32'({busy, req_ack, rsp_valid, rsp_err, spi_rx_start, spi_tx_start}), 32'd0);
        check("reset_data", 32'({rsp_data, spi_tx_data}), 32'd0);
        check("reset_freq", 32'(spi_freq), 32'd3);
        reset = 1'b0;
        @(negedge clk);
        check("idle_no_req", 32'({busy, req_ack != '0}), 32'd0);

        // Directed table, starting from rr pointer 0.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++) begin
                md[i] = tbl[v].mode; dt[i] = tbl[v].data; fq[i] = tbl[v].freq;
            end
            pack();
            req = tbl[v].mask;
            serve(tbl[v].exp_w, tbl[v].exp_data, tbl[v].exp_err, tbl[v].dly,
                  tbl[v].hang, tbl[v].rx, 1'b0);
            req = '0;
        end

        // Two requesters held high: grants alternate 1,0,1,0 and are spaced by the gap.
        for (int i = 0; i < N; i++) begin md[i] = 2'b11; dt[i] = 16'h1000 + 16'(i); fq[i] = 2'(i); end
        pack();
        req = 3'b011;
        prev = -1;
        for (int k = 0; k < 4; k++) begin
            w = (k % 2 == 0) ? 1 : 0;
            serve(w, 16'h6000 + 16'(k), 1'b0, 4, 1'b0, 16'h6000 + 16'(k), 1'b1);
            if (prev >= 0) check("grant_spacing", 32'(grant_cyc - prev >= G + 3), 32'd1);
            prev = grant_cyc;
        end
        req = '0;

        // Reset mid-BUSY: pointer must return to 0 and the aborted frame must stay silent.
        for (int i = 0; i < N; i++) begin md[i] = 2'b01; dt[i] = 16'h9999; fq[i] = 2'b10; end
        pack();
        req = 3'b001;
        w = 0;
        while (req_ack == '0 && w < 8) begin @(negedge clk); w++; end
        check("rst_seq_ack", 32'(req_ack), 32'd1);
        req = '0;
        repeat (4) @(negedge clk);
        check("rst_seq_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_flags", 32'({busy, req_ack, rsp_valid, rsp_err, spi_rx_start, spi_tx_start}), 32'd0);
        check("midrst_data", 32'({rsp_data, spi_tx_data}), 32'd0);
        check("midrst_freq", 32'(spi_freq), 32'd3);
        model_rr = 0;
        hang = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (req_ack != '0 || rsp_valid != '0 || busy) hang = 1'b1;
        end
        check("midrst_silent", 32'(hang), 32'd0);
        for (int i = 0; i < N; i++) begin md[i] = 2'b11; dt[i] = 16'h7070; fq[i] = 2'b01; end
        pack();
        req = 3'b011;
        serve(model_winner(req), 16'h2468, 1'b0, 6, 1'b0, 16'h2468, 1'b0);
        req = '0;

        // Randomized rounds against the request-level model.
        for (int rnd = 0; rnd < 25; rnd++) begin
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                md[i] = 2'($urandom_range(0, 3));
                dt[i] = 16'($urandom);
                fq[i] = 2'($urandom_range(0, 3));
            end
            pack();
            dly  = int'($urandom_range(0, 10));
            hang = ($urandom_range(0, 7) == 0);
            rx   = 16'($urandom);
            req  = mask;
            w    = model_winner(mask);
            err  = (md[w] == 2'b00) || hang;
            exp_d = err ? 16'h0000 : rx;
            serve(w, exp_d, err, dly, hang, rx, 1'b0);
            req = '0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
